// File: rtl/dbg_run_ctrl_if.sv
// Debug run-control bundle between the debug module / pipeline and the
// dbg_run_ctrl sequencer. The slave modport is the sequencer's view.
interface dbg_run_ctrl_if;
  logic       haltreq_i;
  logic       resumereq_i;
  logic       step_i;
  logic       inst_comp_i;
  logic       stall_i;
  logic       halt_active_o;
  logic       reset_stages_o;
  logic       halted_o;
  logic       resume_ack_o;
  logic [1:0] halt_cause_o;
  logic       drain_err_o;

  modport slave (
    input  haltreq_i, resumereq_i, step_i, inst_comp_i, stall_i,
    output halt_active_o, reset_stages_o, halted_o, resume_ack_o,
           halt_cause_o, drain_err_o
  );

  modport master (
    output haltreq_i, resumereq_i, step_i, inst_comp_i, stall_i,
    input  halt_active_o, reset_stages_o, halted_o, resume_ack_o,
           halt_cause_o, drain_err_o
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer for the 3-stage RV32 pipeline.
// Turns halt / resume / single-step requests into halt_active and
// reset_stages controls, waiting on inst_comp for the pipe to drain.
// Optional feature macro: DBG_RUN_CTRL_STEP_EN (single-step support).
module dbg_run_ctrl #(
  parameter int DRAIN_MAX    = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  dbg_run_ctrl_if.slave bus
);

  localparam int              CNT_W      = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2,
    FLUSH  = 3'd3
`ifdef DBG_RUN_CTRL_STEP_EN
    , STEP = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cause_q;
  logic             drain_err_q;
  logic             drain_last, flush_last;
  logic             halt_active, reset_stages, halted, resume_ack;

`ifdef DBG_RUN_CTRL_STEP_EN
  logic             step_q;
`else
  logic             unused_step_ins;
  assign unused_step_ins = bus.step_i ^ bus.stall_i;
`endif

  // One counter serves both the drain timeout and the flush length; it is
  // only meaningful in DRAIN and FLUSH and restarts on every state change.
  assign drain_last = (state_q == DRAIN) && (cnt_q == DRAIN_LAST);
  assign flush_last = (state_q == FLUSH) && (cnt_q == FLUSH_LAST);

  // State register; reset aborts any drain or flush in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Next-state logic; resume beats a simultaneous haltreq in HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (bus.haltreq_i) state_d = DRAIN;
      DRAIN:  if (bus.inst_comp_i || drain_last) state_d = HALTED;
      HALTED: if (bus.resumereq_i) state_d = FLUSH;
      FLUSH: begin
        if (flush_last) begin
`ifdef DBG_RUN_CTRL_STEP_EN
          state_d = step_q ? STEP : RUN;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef DBG_RUN_CTRL_STEP_EN
      STEP:   if (bus.haltreq_i || !bus.stall_i) state_d = DRAIN;
`endif
      default: state_d = RUN;
    endcase
  end

  // Outputs decoded purely from registered state, so no input reaches an
  // output combinationally.
  always_comb begin
    halt_active  = 1'b0;
    reset_stages = 1'b0;
    halted       = 1'b0;
    resume_ack   = 1'b0;
    case (state_q)
      DRAIN:  halt_active = 1'b1;
      HALTED: begin
        halt_active = 1'b1;
        halted      = 1'b1;
      end
      FLUSH: begin
        halt_active  = 1'b1;
        reset_stages = 1'b1;
        resume_ack   = flush_last;
      end
      default: ;
    endcase
  end

  // Cycle counter: cleared on any transition, saturating while it dwells.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else if (state_d != state_q)
      cnt_q <= '0;
    else if ((state_q == DRAIN || state_q == FLUSH) && cnt_q != CNT_SAT)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  // Halt cause is latched on DRAIN entry; a step-completion entry only
  // reports cause 2 when no haltreq is pending at the same time.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cause_q <= 2'd0;
    else if (state_d == DRAIN && state_q != DRAIN) begin
`ifdef DBG_RUN_CTRL_STEP_EN
      cause_q <= (state_q == STEP && !bus.haltreq_i) ? 2'd2 : 2'd1;
`else
      cause_q <= 2'd1;
`endif
    end
  end

  // Sticky drain-timeout flag; a drain completing on the last allowed
  // cycle still counts as success.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      drain_err_q <= 1'b0;
    else if (drain_last && !bus.inst_comp_i)
      drain_err_q <= 1'b1;
  end

`ifdef DBG_RUN_CTRL_STEP_EN
  // dcsr.step is captured as the hart leaves HALTED.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      step_q <= 1'b0;
    else if (state_q == HALTED && bus.resumereq_i)
      step_q <= bus.step_i;
  end
`endif

  assign bus.halt_active_o  = halt_active;
  assign bus.reset_stages_o = reset_stages;
  assign bus.halted_o       = halted;
  assign bus.resume_ack_o   = resume_ack;
  assign bus.halt_cause_o   = cause_q;
  assign bus.drain_err_o    = drain_err_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Self-checking bench for dbg_run_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model each cycle.
module tb_dbg_run_ctrl;

  localparam int DRAIN_MAX    = 16;
  localparam int FLUSH_CYCLES = 2;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_FLUSH = 3, M_STEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dbg_run_ctrl_if bus();

  dbg_run_ctrl #(.DRAIN_MAX(DRAIN_MAX), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode, cycles spent draining, flush cycles remaining.
  int m_mode       = M_RUN;
  int m_age        = 0;
  int m_flush_left = 0;
  int m_cause      = 0;
  bit m_step       = 1'b0;
  bit m_err        = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic enter_drain(input int cause);
    m_mode  = M_DRAIN;
    m_age   = 0;
    m_cause = cause;
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_update();
    if (rst) begin
      m_mode = M_RUN; m_age = 0; m_flush_left = 0;
      m_step = 1'b0;  m_cause = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        M_RUN: if (bus.haltreq_i) enter_drain(1);
        M_DRAIN: begin
          if (bus.inst_comp_i) m_mode = M_HALTED;
          else if (m_age == DRAIN_MAX - 1) begin
            m_mode = M_HALTED;
            m_err  = 1'b1;
          end else m_age++;
        end
        M_HALTED: begin
          if (bus.resumereq_i) begin
            m_mode       = M_FLUSH;
            m_flush_left = FLUSH_CYCLES;
`ifdef DBG_RUN_CTRL_STEP_EN
            m_step       = bus.step_i;
`endif
          end
        end
        M_FLUSH: begin
          if (m_flush_left == 1) m_mode = m_step ? M_STEP : M_RUN;
          else m_flush_left--;
        end
        M_STEP: begin
          if (bus.haltreq_i) enter_drain(1);
          else if (!bus.stall_i) enter_drain(2);
        end
        default: m_mode = M_RUN;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("halt_active", bus.halt_active_o,
        32'(m_mode == M_DRAIN || m_mode == M_HALTED || m_mode == M_FLUSH));
    chk("reset_stages", bus.reset_stages_o, 32'(m_mode == M_FLUSH));
    chk("halted", bus.halted_o, 32'(m_mode == M_HALTED));
    chk("resume_ack", bus.resume_ack_o, 32'(m_mode == M_FLUSH && m_flush_left == 1));
    chk("halt_cause", bus.halt_cause_o, 32'(m_cause));
    chk("drain_err", bus.drain_err_o, 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_halt_active"}, bus.halt_active_o, 0);
    chk({tag, "_reset_stages"}, bus.reset_stages_o, 0);
    chk({tag, "_halted"}, bus.halted_o, 0);
    chk({tag, "_resume_ack"}, bus.resume_ack_o, 0);
    chk({tag, "_cause"}, bus.halt_cause_o, 0);
    chk({tag, "_drain_err"}, bus.drain_err_o, 0);
  endtask

  // From HALTED: resume with the given step value, measure the flush window.
  task automatic resume_measure(input bit step);
    int n, ack_at;
    n = 0; ack_at = 0;
    bus.step_i = step; bus.resumereq_i = 1'b1;
    tick();
    bus.resumereq_i = 1'b0;
    while (bus.reset_stages_o && n < 10) begin
      n++;
      if (bus.resume_ack_o) ack_at = n;
      tick();
    end
    chk("flush_len", n, FLUSH_CYCLES);
    chk("ack_pos", ack_at, FLUSH_CYCLES);
  endtask

  initial begin
    int n;
    bus.haltreq_i = 1'b0; bus.resumereq_i = 1'b0; bus.step_i = 1'b0;
    bus.inst_comp_i = 1'b0; bus.stall_i = 1'b0;

    // Reset state
    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Basic halt: haltreq at cycle 5, inst_comp at cycle 9
    repeat (4) tick();
    bus.haltreq_i = 1'b1; tick(); bus.haltreq_i = 1'b0;
    chk("halt_latency", bus.halt_active_o, 1);
    repeat (3) tick();
    bus.inst_comp_i = 1'b1; tick(); bus.inst_comp_i = 1'b0;
    chk("basic_halted", bus.halted_o, 1);
    chk("basic_cause", bus.halt_cause_o, 1);
    chk("basic_err", bus.drain_err_o, 0);

    // Resume without step
    resume_measure(1'b0);
    chk("resume_run", bus.halt_active_o, 0);

    // Drain timeout
    bus.haltreq_i = 1'b1; tick(); bus.haltreq_i = 1'b0;
    n = 0;
    while (!bus.halted_o && n < 40) begin tick(); n++; end
    chk("timeout_latency", n, DRAIN_MAX);
    chk("timeout_err", bus.drain_err_o, 1);
    resume_measure(1'b0);
    chk("err_sticky", bus.drain_err_o, 1);

    // Simultaneous haltreq and resumereq in HALTED
    bus.haltreq_i = 1'b1; tick();
    bus.inst_comp_i = 1'b1; tick(); bus.inst_comp_i = 1'b0;
    bus.resumereq_i = 1'b1; tick(); bus.resumereq_i = 1'b0;
    chk("both_flush", bus.reset_stages_o, 1);
    repeat (FLUSH_CYCLES) tick();
    chk("both_run", bus.halt_active_o, 0);
    tick();
    chk("both_redrain", bus.halt_active_o, 1);
    chk("both_cause", bus.halt_cause_o, 1);
    bus.haltreq_i = 1'b0;

    // Reset during DRAIN
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("rst_drain");

    // Reset during FLUSH
    bus.haltreq_i = 1'b1; tick(); bus.haltreq_i = 1'b0;
    bus.inst_comp_i = 1'b1; tick(); bus.inst_comp_i = 1'b0;
    bus.resumereq_i = 1'b1; tick(); bus.resumereq_i = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("rst_flush");

    // inst_comp on the timeout cycle counts as success
    bus.haltreq_i = 1'b1; tick(); bus.haltreq_i = 1'b0;
    repeat (DRAIN_MAX - 1) tick();
    bus.inst_comp_i = 1'b1; tick(); bus.inst_comp_i = 1'b0;
    chk("edge_halted", bus.halted_o, 1);
    chk("edge_err", bus.drain_err_o, 0);

    // Single step with a 3-cycle stall
    bus.stall_i = 1'b1;
    resume_measure(1'b1);
`ifdef DBG_RUN_CTRL_STEP_EN
    repeat (3) begin
      chk("step_stalled", bus.halt_active_o, 0);
      tick();
    end
    bus.stall_i = 1'b0; tick();
    chk("step_redrain", bus.halt_active_o, 1);
    bus.inst_comp_i = 1'b1; tick(); bus.inst_comp_i = 1'b0;
    chk("step_cause", bus.halt_cause_o, 2);
    resume_measure(1'b0);
`else
    chk("nostep_run", bus.halt_active_o, 0);
    bus.stall_i = 1'b0;
`endif
    bus.step_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.haltreq_i   = ($urandom_range(0, 7) == 0);
      bus.resumereq_i = ($urandom_range(0, 5) == 0);
      bus.step_i      = $urandom_range(0, 1);
      bus.inst_comp_i = ($urandom_range(0, 9) == 0);
      bus.stall_i     = $urandom_range(0, 1);
      rst             = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Debug run-control sequencer for the 3-stage RV32 pipeline. Converts debug-module requests (halt, resume, single-step) into the pipeline's `halt_active` / `reset_stages` controls. It uses the pipeline's `inst_comp` indication to tell when the pipe has drained after NOP injection. It sits between the debug module and the pipeline top, and is the only driver of the pipeline's debug-support inputs.

## Interface
Parameters:
- `DRAIN_MAX`, default 16: drain timeout in cycles; range 2..255.
- `FLUSH_CYCLES`, default 1: number of cycles `reset_stages_o` is held on resume; range 1..4.

Ports:
- `clk_i`: input, 1 bit. Clock. Single clock domain.
- `reset_i`: input, 1 bit. Reset, synchronous, active-high.
- `haltreq_i`: input, 1 bit. Debug module halt request, level.
- `resumereq_i`: input, 1 bit. Debug module resume request, level. Acted on only in HALTED.
- `step_i`: input, 1 bit. Single-step enable (dcsr.step). Sampled on the HALTED→FLUSH transition.
- `inst_comp_i`: input, 1 bit. Pipeline drained: stages 2 and 3 hold no live instruction.
- `stall_i`: input, 1 bit. Pipeline stall. The PC does not advance while it is high.
- `halt_active_o`: output, 1 bit. To pipeline: inject NOPs and freeze the PC.
- `reset_stages_o`: output, 1 bit. To pipeline: clear the stage registers.
- `halted_o`: output, 1 bit. Hart halted, level.
- `resume_ack_o`: output, 1 bit. Single-cycle pulse when the hart leaves halt.
- `halt_cause_o`: output, 2 bits. Halt cause: 0 none, 1 haltreq, 2 step. Holds its value until the next halt.
- `drain_err_o`: output, 1 bit. Sticky flag: a drain timed out. Cleared only by reset.

## Operation
- Five-state FSM: RUN, DRAIN, HALTED, FLUSH, STEP. All outputs are registered or decoded from the state register only; there is no combinational input→output path.
- **RUN**
  - Outputs: `halt_active_o`=0, `halted_o`=0.
  - `haltreq_i`=1 → DRAIN; cause latched as 1.
- **DRAIN**
  - Outputs: `halt_active_o`=1. The drain counter is cleared on entry and increments each cycle.
  - `inst_comp_i`=1 → HALTED.
  - Otherwise, counter == `DRAIN_MAX`-1 → HALTED, and `drain_err_o` is set.
  - If `inst_comp_i` and timeout occur in the same cycle, the timeout is treated as success: `drain_err_o` is not set.
  - `haltreq_i` deassertion during DRAIN is ignored.
- **HALTED**
  - Outputs: `halt_active_o`=1, `halted_o`=1.
  - `resumereq_i`=1 → FLUSH; `step_i` is latched into `step_q`.
  - `haltreq_i` is ignored in this state.
- **FLUSH**
  - Outputs: `halt_active_o`=1, `reset_stages_o`=1, `halted_o`=0. Lasts exactly `FLUSH_CYCLES` cycles.
  - On exit, `resume_ack_o` pulses for 1 cycle.
  - Next state is STEP if `step_q`=1, otherwise RUN.
- **STEP**
  - Outputs: `halt_active_o`=0.
  - First cycle with `stall_i`=0 (exactly one instruction fetched) → DRAIN; cause latched as 2.
  - `haltreq_i`=1 in STEP → DRAIN with cause 1. Haltreq has priority over step.
- `resumereq_i` outside HALTED is ignored.
- If `haltreq_i` and `resumereq_i` are both high in HALTED, resume wins. Haltreq is then re-evaluated in RUN or STEP.

## Timing
- Reset state is RUN; `step_q`=0; drain counter = 0.
- Reset values of outputs:
  - `halt_active_o`=0, `reset_stages_o`=0, `halted_o`=0, `resume_ack_o`=0.
  - `halt_cause_o`=0, `drain_err_o`=0.
- Reset asserted in any state returns the FSM to RUN on the next edge. This includes aborting an in-progress drain or flush.
- Halt latency:
  - `haltreq_i` high at edge N → `halt_active_o`=1 after edge N.
  - `inst_comp_i` high at edge M → `halted_o`=1 after edge M.
- Timeout: `halted_o` rises after `DRAIN_MAX` cycles in DRAIN.
- Resume latency:
  - `resumereq_i` high at edge N → `reset_stages_o` high during cycles N+1 .. N+`FLUSH_CYCLES`.
  - `resume_ack_o` is high in the last FLUSH cycle.
  - `halt_active_o` drops one cycle after FLUSH ends.
- The counter saturates and never wraps. Its width is the clog2 of (`DRAIN_MAX`+1).

## Configuration
- Macro `DBG_RUN_CTRL_STEP_EN`.
- **Defined:** STEP state and `step_q` are implemented as described above.
- **Undefined:**
  - `step_i` is ignored, and FLUSH always exits to RUN.
  - `halt_cause_o` never takes value 2.
  - The STEP state is not synthesized.

## Test plan
- **Basic halt.** Reset, then `haltreq_i`=1 at cycle 5; `inst_comp_i`=1 at cycle 9.
  - `halt_active_o`=1 from cycle 6.
  - `halted_o`=1 from cycle 10; `halt_cause_o`=1; `drain_err_o`=0.
- **Drain timeout.** `DRAIN_MAX`=16, `inst_comp_i` held 0.
  - `halted_o` rises exactly 16 cycles after DRAIN entry; `drain_err_o`=1.
  - `drain_err_o` stays 1 across a later resume.
- **Resume.** From HALTED, `resumereq_i`=1 with `step_i`=0, `FLUSH_CYCLES`=2.
  - `reset_stages_o` high for 2 cycles; one `resume_ack_o` pulse in the 2nd cycle.
  - `halt_active_o`=0 in the following cycle.
- **Single step (macro defined).** Resume with `step_i`=1 and `stall_i`=1 for 3 cycles.
  - `halt_active_o` stays 0 until `stall_i` falls, then returns to 1.
  - Re-halts with `halt_cause_o`=2.
- **Same-cycle requests.** `haltreq_i` and `resumereq_i` both high in HALTED.
  - FLUSH, then RUN, then DRAIN again with cause 1.
- **Reset mid-operation.** Assert `reset_i` during DRAIN and during FLUSH.
  - All outputs at reset values on the next cycle; FSM in RUN.
